// File: rtl/mux8_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter_if
// Bundles the request/grant signals between the eight requesters and the
// round-robin arbiter that drives the shared 8-to-1 mux.
//   req   [7:0] : level request, one bit per requester
//   sel   [2:0] : granted index, drives mux S
//   en          : grant active, drives mux E
//   grant [7:0] : one-hot copy of the grant (0 when en = 0)
// Modports:
//   master : arbiter side (samples req, drives sel/en/grant)
//   slave  : requester side (drives req, observes sel/en/grant)
// ---------------------------------------------------------------------------
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic [2:0] sel;
  logic       en;
  logic [7:0] grant;

  modport master (input req, output sel, output en, output grant);
  modport slave  (output req, input sel, input en, input grant);
endinterface

// File: rtl/mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter
// Round-robin arbiter/sequencer for the shared 8-to-1 mux. Each grant is held
// for at most HOLD_CYCLES cycles (shorter if the owner drops its request) and
// is always followed by one dead cycle with en = 0 for a clean handover.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : mux8_rr_arbiter_if.master (req in; sel/en/grant out, all registered)
// Parameter:
//   HOLD_CYCLES : max grant length in cycles, legal range 1..16
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant (en = 0); search req from ptr upward each edge
// GRANT | requester sel owns the mux (en = 1); count hold cycles
// ---------------------------------------------------------------------------
module mux8_rr_arbiter #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  mux8_rr_arbiter_if.master         bus
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic [7:0]       grant_q, grant_d;

  logic             found;
  logic [2:0]       pick;
  logic [2:0]       idx;

  // Rotating priority search: walk offsets from 7 down to 0 so the last
  // hit written is the one closest to ptr (lowest index at/above ptr, with wrap).
  always_comb begin
    found = 1'b0;
    pick  = 3'd0;
    idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr_q + 3'(i);
      if (bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = pick;
          cnt_d   = '0;
          ptr_d   = pick + 3'd1;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q] || (cnt_q == CNT_MAX)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they change on the
    // same edge as the state itself.
    en_d    = (state_d == GRANT);
    grant_d = en_d ? (8'b1 << sel_d) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      grant_q <= 8'h00;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      grant_q <= grant_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.en    = en_q;
  assign bus.grant = grant_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  mux8_rr_arbiter_if arb_if ();

  mux8_rr_arbiter #(.HOLD_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (arb_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic e, input logic [2:0] s,
                       input logic [7:0] g);
    n_assert++;
    assert ({arb_if.en, arb_if.sel, arb_if.grant} === {e, s, g}) else begin
      n_fail++;
      $error("FAIL %s: observed en=%0b sel=%0d grant=%h, expected en=%0b sel=%0d grant=%h",
             tag, arb_if.en, arb_if.sel, arb_if.grant, e, s, g);
    end
  endtask

  // n grant cycles for requester k (first one already reached by a tick
  // when first_done is set), followed by the dead cycle.
  task automatic grant_period(input string tag, input logic [2:0] k, input int n,
                              input bit first_done);
    for (int c = 0; c < n; c++) begin
      if (!(first_done && c == 0)) tick();
      check(tag, 1'b1, k, 8'b1 << k);
    end
    tick();
    check({tag, "_dead"}, 1'b0, k, 8'h00);
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    arb_if.req = 8'hFF;

    // Reset held for 3 edges with everyone requesting
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset", 1'b0, 3'd0, 8'h00);
    end
    rst = 1'b0;

    // All requesting: 0..7 then 0 again, 4 cycles each plus a dead cycle
    for (int k = 0; k < 9; k++) begin
      grant_period("all_req", 3'(k % 8), 4, 1'b0);
    end
    // ptr = 1 now; drop all requests, stay idle
    arb_if.req = 8'h00;
    tick();
    check("idle_noreq", 1'b0, 3'd0, 8'h00);

    // Single requester 5: two full periods
    arb_if.req = 8'h20;
    grant_period("single5_a", 3'd5, 4, 1'b0);
    grant_period("single5_b", 3'd5, 4, 1'b0);

    // Early release: requester 3 drops in its second grant cycle
    arb_if.req = 8'h08;
    tick();
    check("early_c1", 1'b1, 3'd3, 8'h08);
    tick();
    check("early_c2", 1'b1, 3'd3, 8'h08);
    arb_if.req = 8'h00;
    tick();
    check("early_drop", 1'b0, 3'd3, 8'h00);
    tick();
    check("early_idle1", 1'b0, 3'd3, 8'h00);
    tick();
    check("early_idle2", 1'b0, 3'd3, 8'h00);

    // Wrap-around: 7 first, then 0, 7, 0
    arb_if.req = 8'h80;
    tick();
    check("wrap_7a_first", 1'b1, 3'd7, 8'h80);
    arb_if.req = 8'h81;
    grant_period("wrap_7a", 3'd7, 4, 1'b1);
    grant_period("wrap_0a", 3'd0, 4, 1'b0);
    grant_period("wrap_7b", 3'd7, 4, 1'b0);
    tick();
    check("wrap_0b", 1'b1, 3'd0, 8'h01);

    // Requester 0 drops; ptr = 1 so requester 4 is next
    arb_if.req = 8'h10;
    tick();
    check("to4_dead", 1'b0, 3'd0, 8'h00);
    tick();
    check("g4_c1", 1'b1, 3'd4, 8'h10);
    tick();
    check("g4_c2", 1'b1, 3'd4, 8'h10);

    // Reset mid-grant in the 2nd cycle of the sel=4 grant
    rst        = 1'b1;
    arb_if.req = 8'h11;
    tick();
    check("mid_reset", 1'b0, 3'd0, 8'h00);
    rst = 1'b0;
    grant_period("post_reset0", 3'd0, 4, 1'b0);
    tick();
    check("post_reset4", 1'b1, 3'd4, 8'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer for the team's 8-to-1 multiplexer (`Multiplexer8to1`). It shares the single mux output among eight requesters. It drives the mux select `S` and enable `E` directly from registered state. It holds each grant for a bounded number of cycles and inserts one dead cycle between grants so downstream logic sees a clean handover.

## Interface
- `HOLD_CYCLES`, default 4: maximum consecutive cycles a grant is held. Legal range is 1..16.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  8  `req[i]` = requester i wants the mux output; level-sensitive.
- `sel`  output  3  binary index of the granted requester; drives mux `S`.
- `en`  output  1  grant active; drives mux `E`.
- `grant`  output  8  one-hot copy of the grant. It equals `1<<sel` when `en`=1 and 0 otherwise.

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- Two states: IDLE and GRANT. Internal registers:
  - `ptr`, 3 bits: search start index.
  - `cnt`: hold counter, wide enough for `HOLD_CYCLES`-1.
- Reset values (all outputs registered):
  - state = IDLE
  - `sel` = 0, `en` = 0, `grant` = 8'h00
  - `ptr` = 0, `cnt` = 0
- IDLE behaviour:
  - `en` = 0.
  - Each edge, search `req` starting at index `ptr` and ascending modulo 8 (7 wraps to 0). Take the first set bit, index k.
  - If one is found: state ← GRANT, `sel` ← k, `cnt` ← 0, `ptr` ← (k+1) mod 8.
  - If `req` = 0: remain in IDLE; `sel` and `ptr` are unchanged.
- GRANT behaviour:
  - `en` = 1.
  - Each edge, if `req[sel]` = 0 or `cnt` = `HOLD_CYCLES`-1: state ← IDLE, `cnt` ← 0.
  - Otherwise `cnt` ← `cnt`+1.
- Fairness: `ptr` always points past the last granted requester, so no requester waits more than 7 grants.
- Other requesters' `req` changes during GRANT are ignored until the next IDLE evaluation.
- `sel` keeps the last granted index in IDLE. `en` = 0 masks the mux output.
- `HOLD_CYCLES` = 1: every grant lasts exactly one cycle.

## Timing
- Request-to-grant latency:
  - `req` first high during an IDLE cycle → `en`, `sel` and `grant` valid after the next rising edge (1 cycle).
  - `req` first high during another requester's grant → served only after that grant ends and the dead cycle passes.
- Grant length:
  - With `req[sel]` held high, `en` = 1 for exactly `HOLD_CYCLES` cycles.
  - If `req[sel]` is sampled low at an edge during GRANT, `en` falls at that edge. Grant length is then the number of edges at which it was sampled high, plus 1.
- Handover: `en` = 0 for exactly one cycle between consecutive grants, including a re-grant to the same requester.
  - Steady-state all-requesting period per requester = `HOLD_CYCLES`+1 cycles.
- Simultaneous events:
  - Release and reset at the same edge: reset wins.
  - Multiple `req` bits set in IDLE: lowest index at or above `ptr` (with wrap) wins.
- Reset mid-operation: at the first edge with `rst` = 1, all registers take reset values and the grant aborts (`en` = 0 next cycle). `ptr` returns to 0.
- First arbitration after reset occurs at the first rising edge with `rst` = 0.

## Test plan
All scenarios use `HOLD_CYCLES` = 4.
- **Reset:** `rst` = 1 for 3 edges with `req` = 8'hFF.
  - During reset: `en` = 0, `sel` = 0, `grant` = 8'h00.
  - First edge with `rst` = 0: `en` = 1, `sel` = 0, `grant` = 8'h01.
- **Single requester:** `req` = 8'h20 held.
  - `sel` = 5 throughout.
  - `en` pattern 1,1,1,1,0 repeating; `grant` = 8'h20 while `en` = 1.
- **All requesting:** `req` = 8'hFF.
  - `sel` sequence 0,1,2,…,7,0, each held 4 cycles.
  - One `en` = 0 cycle between each grant.
- **Early release:** `req` = 8'h08; deassert `req[3]` in the second grant cycle.
  - `en` high exactly 2 cycles, then 0.
  - State stays IDLE while `req` = 0.
- **Wrap-around:** grant requester 7 first, then `req` = 8'h81.
  - Next grant is `sel` = 0 (`ptr` wrapped), then 7, then 0.
- **Reset mid-grant:** assert `rst` during the 2nd cycle of a `sel` = 4 grant.
  - `en` = 0 at the following edge.
  - After release with `req` = 8'h11, the first grant is `sel` = 0, not 4.
